// File: rtl/sequence_manager_if.sv
// Graphics flash handshake and player key strobe shared by the sequence manager and its peers.
interface sequence_manager_if;
  logic       flash_req;
  logic [1:0] flash_tile;
  logic       flash_done;
  logic       key_valid;
  logic [1:0] key_tile;

  modport master (
    output flash_req,
    output flash_tile,
    input  flash_done,
    input  key_valid,
    input  key_tile
  );

  modport slave (
    input  flash_req,
    input  flash_tile,
    output flash_done,
    output key_valid,
    output key_tile
  );
endinterface

// File: rtl/sequence_manager.sv
// Memory-tile game controller: captures a random sequence, flashes it through the
// graphics handshake, then scores the player's key presses against it.
module sequence_manager #(
  parameter int MAX_LEN = 9
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [4:0]         difficulty_i,
  input  logic [1:0]         rand_tile_i,
  sequence_manager_if.master bus,
  output logic               busy_o,
  output logic               awaiting_input_o,
  output logic               win_o,
  output logic               lose_o,
  output logic [3:0]         progress_o,
  output logic [3:0]         seq_len_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_PLAY,
    S_GAP,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] progress_q, progress_d;
  logic [3:0] seq_len_q, seq_len_d;
  logic [3:0] clamp_len;
  logic [3:0] last_idx;
  logic       store_we;
  logic [1:0] store_rd;
  logic [1:0] store_q [MAX_LEN];

  assign store_rd = store_q[idx_q];
  assign last_idx = seq_len_q - 4'd1;

  // The whole 5-bit request is compared so that e.g. 16..31 saturate instead of wrapping.
  always_comb begin
    if (difficulty_i == 5'd0) begin
      clamp_len = 4'd1;
    end else if (difficulty_i > 5'(MAX_LEN)) begin
      clamp_len = 4'(MAX_LEN);
    end else begin
      clamp_len = difficulty_i[3:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    progress_d = progress_q;
    seq_len_d  = seq_len_q;
    store_we   = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_i) begin
          seq_len_d  = clamp_len;
          idx_d      = 4'd0;
          progress_d = 4'd0;
          state_d    = S_GEN;
        end
      end
      S_GEN: begin
        store_we = 1'b1;
        if (idx_q == last_idx) begin
          idx_d   = 4'd0;
          state_d = S_PLAY;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_PLAY: begin
        if (bus.flash_done) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (idx_q == seq_len_q) begin
          idx_d   = 4'd0;
          state_d = S_INPUT;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_INPUT: begin
        if (bus.key_valid) begin
          if (bus.key_tile == store_rd) begin
            progress_d = progress_q + 4'd1;
            idx_d      = idx_q + 4'd1;
            if (idx_q == last_idx) begin
              state_d = S_WIN;
            end
          end else begin
            state_d = S_LOSE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      progress_q <= 4'd0;
      seq_len_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      progress_q <= progress_d;
      seq_len_q  <= seq_len_d;
    end
  end

  // Store contents survive reset; every round rewrites them before reading.
  always_ff @(posedge clock) begin
    if (store_we) begin
      store_q[idx_q] <= rand_tile_i;
    end
  end

  assign bus.flash_req    = (state_q == S_PLAY);
  assign bus.flash_tile   = (state_q == S_PLAY) ? store_rd : 2'd0;
  assign busy_o           = !(state_q inside {S_IDLE, S_WIN, S_LOSE});
  assign awaiting_input_o = (state_q == S_INPUT);
  assign win_o            = (state_q == S_WIN);
  assign lose_o           = (state_q == S_LOSE);
  assign progress_o       = progress_q;
  assign seq_len_o        = seq_len_q;

endmodule

// File: doc/sequence_manager.md
# sequence_manager

Game-sequence controller for the memory-tile game. It latches the chosen difficulty and captures one random tile per step into an internal sequence store. It then drives the graphics controller through a request/done handshake to flash each stored tile in order. Finally it checks the player's key presses against the stored sequence and reports win or lose. It sits between the LFSR, the player-input debouncer and the graphics control/datapath pair.

## Interface
- MAX_LEN, 9, maximum sequence length (1..15)
- clock  in  1  system clock, all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a new round
- difficulty  in  5  requested sequence length
- rand_tile  in  2  current random tile from the LFSR
- flash_req  out  1  request to the graphics controller to flash flash_tile
- flash_tile  out  2  tile to flash; valid while flash_req is high
- flash_done  in  1  one-cycle pulse from graphics: flash and redraw finished
- key_valid  in  1  one-cycle pulse: player pressed a tile key
- key_tile  in  2  tile pressed; valid with key_valid
- busy  out  1  high in every state except IDLE, WIN and LOSE
- awaiting_input  out  1  high in INPUT
- win  out  1  high in WIN
- lose  out  1  high in LOSE
- progress  out  4  number of correct presses this round
- seq_len  out  4  latched length of the current round

## Operation
- States: IDLE, GEN, PLAY, GAP, INPUT, WIN, LOSE.
- Reset (asynchronous): state goes to IDLE. All outputs are 0, including seq_len, progress and flash_tile. The index and step counters clear. Store contents are not cleared and are never read before they are regenerated.
- IDLE/WIN/LOSE, start=1:
  - Latch len = clamp(difficulty, 1, MAX_LEN) into seq_len.
  - Clear the index and progress.
  - Go to GEN.
- In all other states, start is ignored.
- GEN:
  - Each cycle, write rand_tile into store[idx] and increment idx.
  - After writing entry len-1, clear idx and go to PLAY.
  - GEN lasts exactly len cycles.
- PLAY:
  - flash_req=1 and flash_tile=store[idx], held stable until flash_done.
  - On flash_done, increment idx and go to GAP.
  - flash_done in any other state is ignored.
- GAP:
  - One cycle with flash_req=0.
  - If idx==len, clear idx and go to INPUT; otherwise go to PLAY.
- INPUT, key_valid=1:
  - If key_tile==store[idx]: increment progress and idx. If this was entry len-1, go to WIN.
  - If key_tile differs: go to LOSE. progress holds its value.
- key_valid outside INPUT is ignored, including keys that arrive during PLAY or GAP.
- WIN/LOSE hold, with progress and seq_len frozen, until start.
- Arithmetic:
  - idx and progress are 4-bit unsigned and never exceed len.
  - The clamp compares the full 5-bit difficulty. Values 0 map to 1; values above MAX_LEN map to MAX_LEN.

## Timing
- start sampled at edge N: GEN from N+1 through N+len. First flash_req is high at N+len+1.
- flash_done sampled at edge M: GAP in cycle M+1, flash_req=0. Next flash_req at M+2, or awaiting_input at M+2 after the last tile.
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- Simultaneous start and key_valid in WIN/LOSE: start wins and the key is dropped.
- Mid-round reset: within the same cycle, flash_req drops to 0 and busy, win, lose and awaiting_input go to 0. No further flash requests are issued until a new start.
- flash_done arriving in the first PLAY cycle is accepted, so one-cycle handshake latency is legal.

## Test plan
- Reset, then difficulty=3, start, rand_tile=2,0,3 on GEN cycles, flash_done 5 cycles after each request -> flash_tile sequence 2,0,3 with a one-cycle low gap between requests. awaiting_input=1 two cycles after the third flash_done.
- After the scenario above, keys 2,0,3 -> progress 1,2,3 and win=1 the cycle after the third key; a following start restarts with busy=1.
- difficulty=6 with keys 1,2,1 against a store of 1,2,3,... -> lose=1 after the third key, progress=2; later keys ignored.
- difficulty=0 -> seq_len=1; difficulty=31 -> seq_len=9 with exactly 9 flash requests.
- key_valid pulses during PLAY, and start pulses during GEN and INPUT -> no change to state, progress, seq_len or the store.
- resetn low for one cycle while flash_req=1 in round 2 -> all outputs 0 immediately; IDLE held until start; the next round regenerates the sequence from rand_tile.
